ram_loader: RTL and testbench

Boot-time program loader and the write-side initiator on the CPU-RAM interface. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It writes each word to RAM, optionally reads it back to verify it, and holds the CPU in reset until the image is fully in memory. It sits beside `memory_controller` as a second initiator that owns the RAM port while `cpu_hold` is asserted.

---
 rtl/rv32ima_pkg.sv | 30 +++
 rtl/byte_packer.sv | 44 ++++
 rtl/ram_loader.sv | 148 ++++++++++++++
 tb/tb_ram_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima CPU/RAM subsystem.
//   ram_state_t    : status returned by the RAM port (FREE/BUSY/ACCESS/ERROR)
//   loader_state_t : control states of the boot-time ram_loader
//   LOADER_WORD_BYTES : bytes packed into one RAM word by the loader
//   word_align()   : clears the byte-offset bits of an address
package rv32ima_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ram_state_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    READ,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned LOADER_WORD_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer for ram_loader.
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   i_clear    : zero the word and restart at lane 0 (wins over i_push)
//   i_push     : insert i_byte into the current lane and advance the lane
//   i_byte     : byte to insert
//   o_word     : packed word; lanes not yet written read as zero
//   o_full     : this push fills the last lane of the word
module byte_packer
  import rv32ima_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [31:0] w_ins;

  // Lane idx occupies bits [8*idx+7 : 8*idx]; OR-insert relies on the
  // word being cleared before each new word.
  assign w_ins  = {24'b0, i_byte} << {r_idx, 3'b000};
  assign o_full = i_push && (r_idx == 2'(LOADER_WORD_BYTES - 1));
  assign o_word = r_word;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_push) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= r_word | w_ins;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Boot-time program loader: packs a byte stream into 32-bit little-endian
// words, writes them to RAM (optionally reading each back to verify) and
// holds the CPU in reset until the image is in memory.
// Ports:
//   clk, nrst            : clock, asynchronous active-low reset
//   start                : load request, honoured in IDLE/DONE/ERR only
//   base_addr, byte_len  : image destination and length, captured with start
//   in_data/in_valid/in_ready : byte stream handshake
//   ram_addr/ram_store/ram_wen/ram_ren : RAM request (initiator side)
//   ram_load/ram_state   : RAM read data and status
//   cpu_hold             : keeps the CPU in reset and owns the RAM port
//   done, error          : level status of the last load
module ram_loader
  import rv32ima_pkg::*;
#(
  parameter bit          VERIFY = 1'b1,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] byte_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_store,
  output logic             ram_wen,
  output logic             ram_ren,
  input  logic [31:0]      ram_load,
  input  ram_state_t       ram_state,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  loader_state_t    r_state, w_next;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_remaining;

  logic        w_start_ok;
  logic        w_load;
  logic        w_push;
  logic        w_last_byte;
  logic        w_more;
  logic        w_advance;
  logic        w_clear;
  logic        w_full;
  logic [31:0] w_word;

  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_load      = w_start_ok && (byte_len != '0);
  assign w_push      = in_valid && (r_state == COLLECT);
  assign w_last_byte = (r_remaining == LEN_W'(1));
  // Evaluated in WRITE/READ, after the word's bytes were already counted.
  assign w_more      = (r_remaining != '0);
  assign w_clear     = w_load || w_advance;

  byte_packer u_packer (
    .clk     (clk),
    .nrst    (nrst),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_next = (byte_len == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (w_push && (w_full || w_last_byte)) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        if (ram_state == ERROR) begin
          w_next = ERR;
        end else if (ram_state == ACCESS) begin
          if (VERIFY) begin
            w_next = READ;
          end else begin
            w_advance = 1'b1;
            w_next    = w_more ? COLLECT : DONE;
          end
        end
      end
      READ: begin
        if (ram_state == ERROR) begin
          w_next = ERR;
        end else if (ram_state == ACCESS) begin
          if (ram_load == w_word) begin
            w_advance = 1'b1;
            w_next    = w_more ? COLLECT : DONE;
          end else begin
            w_next = ERR;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_addr      <= word_align(base_addr);
      r_remaining <= byte_len;
    end else begin
      if (w_push) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_advance) begin
        r_addr <= r_addr + 32'(LOADER_WORD_BYTES);
      end
    end
  end

  // Every request/status output is a pure state decode or a register, so
  // ram_state/ram_load never reach the RAM request outputs combinationally.
  assign in_ready  = (r_state == COLLECT);
  assign ram_wen   = (r_state == WRITE);
  assign ram_ren   = (r_state == READ);
  assign ram_addr  = r_addr;
  assign ram_store = w_word;
  assign cpu_hold  = (r_state != DONE);
  assign done      = (r_state == DONE);
  assign error     = (r_state == ERR);

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
  import rv32ima_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] byte_len = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ram_addr, ram_store;
  logic        ram_wen, ram_ren;
  logic [31:0] ram_load = '0;
  ram_state_t  ram_state = FREE;
  logic        cpu_hold, done, error;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_loader #(.VERIFY(1'b1), .LEN_W(16)) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .byte_len(byte_len), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_load(ram_load),
    .ram_state(ram_state), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // Byte source: presents src_q[0]; a byte is consumed when valid & ready
  // were both high at the preceding rising edge.
  logic [7:0] src_q[$];
  bit prev_hs = 0;
  bit gaps = 0;
  always @(negedge clk) begin
    if (!nrst) begin
      src_q.delete();
      in_valid = 1'b0;
      prev_hs  = 0;
    end else begin
      if (prev_hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      prev_hs = in_valid && in_ready;
    end
  end

  // RAM model: answers a request after `lat` BUSY cycles.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog_addr[$], wlog_data[$];
  int lat = 0, wait_cnt = 0, rd_cnt = 0;
  bit corrupt = 0, force_err = 0;
  always @(negedge clk) begin
    if (!nrst || !(ram_wen || ram_ren)) begin
      ram_state = FREE;
      wait_cnt  = 0;
    end else if (wait_cnt >= lat) begin
      wait_cnt = 0;
      if (force_err) begin
        ram_state = ERROR;
      end else begin
        ram_state = ACCESS;
        if (ram_wen) begin
          mem[ram_addr] = ram_store;
          wlog_addr.push_back(ram_addr);
          wlog_data.push_back(ram_store);
        end else begin
          ram_load = corrupt ? 32'hDEADBEEF : (mem.exists(ram_addr) ? mem[ram_addr] : '0);
          rd_cnt++;
        end
      end
    end else begin
      ram_state = BUSY;
      wait_cnt++;
    end
  end

  // Reference model: byte i lands in word i/4 at bit offset 8*(i%4),
  // word k at aligned base + 4k (mod 2^32).
  logic [31:0] exp_addr[$], exp_data[$];
  function automatic void build_exp(input logic [31:0] b, input logic [7:0] bytes[$]);
    exp_addr.delete();
    exp_data.delete();
    for (int unsigned i = 0; i < bytes.size(); i++) begin
      if (i % 4 == 0) begin
        exp_addr.push_back((b & ~32'h3) + 32'(4 * (i / 4)));
        exp_data.push_back('0);
      end
      exp_data[i / 4] = exp_data[i / 4] | (32'(bytes[i]) << (8 * (i % 4)));
    end
  endfunction

  task automatic do_start(input logic [31:0] b, input int len);
    @(negedge clk);
    base_addr = b;
    byte_len  = 16'(len);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (done || error) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_load(input logic [31:0] b, input logic [7:0] bytes[$], output bit ok);
    @(negedge clk);
    wlog_addr.delete();
    wlog_data.delete();
    rd_cnt = 0;
    foreach (bytes[i]) src_q.push_back(bytes[i]);
    build_exp(b, bytes);
    do_start(b, bytes.size());
    wait_end(3000, ok);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    n_vec++; if (ram_addr !== 32'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
    n_vec++; if (ram_store !== 32'h0) begin n_err++; $display("FAIL reset_ram_store: got %h expected 0", ram_store); end
    n_vec++; if ({in_ready, ram_wen, ram_ren, done, error} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got rdy/wen/ren/done/err=%b expected 00000", {in_ready, ram_wen, ram_ren, done, error});
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    n_vec++; if ({cpu_hold, in_ready, done} !== 3'b100) begin
      n_err++; $display("FAIL idle_after_reset: got hold/rdy/done=%b expected 100", {cpu_hold, in_ready, done});
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] bytes[$];
    bit ok;
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    do_start(32'h40, 8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    n_vec++; if ({cpu_hold, in_ready, ram_wen, ram_ren, done, error} !== 6'b100000 || ram_addr !== 32'h0 || ram_store !== 32'h0) begin
      n_err++; $display("FAIL midload_reset: got hold/rdy/wen/ren/done/err=%b addr=%h store=%h expected 100000 0 0",
                        {cpu_hold, in_ready, ram_wen, ram_ren, done, error}, ram_addr, ram_store);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 nrst = 1'b1;
    bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load(32'h0, bytes, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL reload_timeout: got no done/error expected done"); end
    n_vec++; if (wlog_addr.size() !== 2) begin n_err++; $display("FAIL reload_count: got %0d expected 2", wlog_addr.size()); end
    n_vec++; if (wlog_data.size() > 1 && (wlog_addr[0] !== 32'h0 || wlog_data[0] !== 32'h33221100 || wlog_addr[1] !== 32'h4 || wlog_data[1] !== 32'h77665544)) begin
      n_err++; $display("FAIL reload_words: got %h@%h %h@%h expected 33221100@0 77665544@4", wlog_data[0], wlog_addr[0], wlog_data[1], wlog_addr[1]);
    end
    n_vec++; if ({done, cpu_hold, error} !== 3'b100) begin
      n_err++; $display("FAIL reload_status: got done/hold/err=%b expected 100", {done, cpu_hold, error});
    end
  endtask

  task automatic test_short_word();
    logic [7:0] bytes[$];
    bit ok;
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(32'h1000, bytes, ok);
    n_vec++; if (!ok || !done) begin n_err++; $display("FAIL short_done: got ok=%b done=%b expected 1 1", ok, done); end
    n_vec++; if (wlog_addr.size() !== 2) begin n_err++; $display("FAIL short_count: got %0d expected 2", wlog_addr.size()); end
    n_vec++; if (wlog_data.size() > 1 && (wlog_data[0] !== 32'hDDCCBBAA || wlog_addr[0] !== 32'h1000 || wlog_data[1] !== 32'h0000FFEE || wlog_addr[1] !== 32'h1004)) begin
      n_err++; $display("FAIL short_words: got %h@%h %h@%h expected DDCCBBAA@1000 0000FFEE@1004", wlog_data[0], wlog_addr[0], wlog_data[1], wlog_addr[1]);
    end
  endtask

  task automatic test_stall();
    logic [7:0] bytes[$];
    logic [31:0] a0, s0;
    int k, cnt;
    bit stable, ok;
    for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom));
    build_exp(32'h200, bytes);
    lat = 5;
    @(negedge clk);
    foreach (bytes[i]) src_q.push_back(bytes[i]);
    do_start(32'h200, 4);
    k = 0;
    while (!ram_wen && k < 50) begin @(negedge clk); k++; end
    n_vec++; if (!ram_wen) begin n_err++; $display("FAIL stall_wen_start: got wen=0 expected 1 within 50 cycles"); end
    a0 = ram_addr; s0 = ram_store; cnt = 0; stable = 1;
    while (ram_wen && cnt < 20) begin
      if (ram_addr !== a0 || ram_store !== s0 || in_ready !== 1'b0) stable = 0;
      cnt++;
      @(negedge clk);
    end
    n_vec++; if (cnt !== 6) begin n_err++; $display("FAIL stall_wen_cycles: got %0d expected 6", cnt); end
    n_vec++; if (!stable) begin n_err++; $display("FAIL stall_stable: got unstable addr/store/in_ready expected stable, in_ready=0"); end
    n_vec++; if (a0 !== 32'h200 || s0 !== exp_data[0]) begin n_err++; $display("FAIL stall_word: got %h@%h expected %h@00000200", s0, a0, exp_data[0]); end
    n_vec++; if ({ram_wen, ram_ren} !== 2'b01) begin n_err++; $display("FAIL stall_after_access: got wen/ren=%b expected 01", {ram_wen, ram_ren}); end
    wait_end(100, ok);
    n_vec++; if (!ok || !done) begin n_err++; $display("FAIL stall_done: got ok=%b done=%b expected 1 1", ok, done); end
    lat = 0;
  endtask

  task automatic test_latency();
    logic [7:0] bytes[$];
    int cyc;
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    @(negedge clk);
    foreach (bytes[i]) src_q.push_back(bytes[i]);
    do_start(32'h80, 8);
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc !== 12) begin n_err++; $display("FAIL lat0_cycles: got %0d expected 12", cyc); end
  endtask

  task automatic test_mismatch();
    logic [7:0] bytes[$];
    bit ok;
    bytes = '{8'h00, 8'h01, 8'h02, 8'h03};
    corrupt = 1;
    run_load(32'h300, bytes, ok);
    corrupt = 0;
    n_vec++; if (!ok || {error, done, cpu_hold} !== 3'b101) begin
      n_err++; $display("FAIL mismatch_status: got ok=%b err/done/hold=%b expected 1 101", ok, {error, done, cpu_hold});
    end
    n_vec++; if (wlog_data.size() < 1 || wlog_data[0] !== 32'h03020100) begin n_err++; $display("FAIL mismatch_written: got %0d writes expected 03020100", wlog_data.size()); end
    force_err = 1;
    run_load(32'h400, bytes, ok);
    force_err = 0;
    n_vec++; if (!ok || {error, done, cpu_hold} !== 3'b101 || wlog_addr.size() !== 0) begin
      n_err++; $display("FAIL ram_error: got ok=%b err/done/hold=%b writes=%0d expected 1 101 0", ok, {error, done, cpu_hold}, wlog_addr.size());
    end
  endtask

  task automatic test_zero_len();
    bit saw_req;
    wlog_addr.delete();
    do_start(32'h500, 0);
    n_vec++; if ({done, error, cpu_hold} !== 3'b100) begin n_err++; $display("FAIL zero_len_done: got done/err/hold=%b expected 100", {done, error, cpu_hold}); end
    saw_req = 0;
    repeat (5) begin
      if (ram_wen || ram_ren || in_ready) saw_req = 1;
      @(negedge clk);
    end
    n_vec++; if (saw_req || wlog_addr.size() !== 0 || !done) begin n_err++; $display("FAIL zero_len_no_req: got req=%b done=%b expected 0 1", saw_req, done); end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes[$];
    bit ok;
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    run_load(32'hFFFF_FFFC, bytes, ok);
    n_vec++; if (!ok || wlog_addr.size() !== 2) begin n_err++; $display("FAIL wrap_count: got ok=%b writes=%0d expected 1 2", ok, wlog_addr.size()); end
    n_vec++; if (wlog_addr.size() > 1 && (wlog_addr[0] !== 32'hFFFF_FFFC || wlog_addr[1] !== 32'h0 || wlog_data[1] !== exp_data[1])) begin
      n_err++; $display("FAIL wrap_addr: got %h %h data %h expected FFFFFFFC 00000000 data %h", wlog_addr[0], wlog_addr[1], wlog_data[1], exp_data[1]);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] bytes[$];
    bit ok;
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    @(negedge clk);
    wlog_addr.delete();
    wlog_data.delete();
    foreach (bytes[i]) src_q.push_back(bytes[i]);
    build_exp(32'h600, bytes);
    do_start(32'h600, 8);
    @(negedge clk);
    base_addr = 32'h900; byte_len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(200, ok);
    n_vec++; if (!ok || !done || wlog_addr.size() !== 2) begin n_err++; $display("FAIL ignore_start: got ok=%b done=%b writes=%0d expected 1 1 2", ok, done, wlog_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < wlog_addr.size(); i++) begin
      n_vec++; if (wlog_addr[i] !== exp_addr[i] || wlog_data[i] !== exp_data[i]) begin
        n_err++; $display("FAIL ignore_start_w%0d: got %h@%h expected %h@%h", i, wlog_data[i], wlog_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    logic [31:0] b;
    int len;
    bit ok;
    gaps = 1;
    for (int it = 0; it < 20; it++) begin
      bytes.delete();
      len = $urandom_range(1, 23);
      b   = $urandom;
      lat = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
      build_exp(b, bytes);
      @(negedge clk);
      wlog_addr.delete();
      wlog_data.delete();
      rd_cnt = 0;
      foreach (bytes[i]) src_q.push_back(bytes[i]);
      do_start(b, len);
      n_vec++; if ({done, error, cpu_hold, in_ready} !== 4'b0011) begin
        n_err++; $display("FAIL rand%0d_restart: got done/err/hold/rdy=%b expected 0011", it, {done, error, cpu_hold, in_ready});
      end
      wait_end(3000, ok);
      n_vec++; if (!ok || {done, error, cpu_hold} !== 3'b100 || wlog_addr.size() !== exp_addr.size() || rd_cnt !== exp_addr.size()) begin
        n_err++; $display("FAIL rand%0d_status: got ok=%b done/err/hold=%b writes=%0d reads=%0d expected 1 100 %0d %0d",
                          it, ok, {done, error, cpu_hold}, wlog_addr.size(), rd_cnt, exp_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wlog_addr.size(); i++) begin
        n_vec++; if (wlog_addr[i] !== exp_addr[i] || wlog_data[i] !== exp_data[i]) begin
          n_err++; $display("FAIL rand%0d_w%0d: got %h@%h expected %h@%h", it, i, wlog_data[i], wlog_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    gaps = 0;
    lat  = 0;
  endtask

  initial begin
    test_reset();
    test_reset_midload();
    test_short_word();
    test_stall();
    test_latency();
    test_mismatch();
    test_zero_len();
    test_wrap();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
